snoopy_game_sequencer: RTL and testbench

Top-level game sequencer for the Snoopy runner. It owns the game state (idle, running, dying, over) and generates the frame tick that paces the vertical-motion physics. It conditions the raw jump and start buttons into buffered, rate-limited jump requests and holds the physics block in reset outside play. It also keeps the run score.

---
 rtl/snoopy_game_sequencer.sv | 174 +++++++++++++++++
 tb/tb_snoopy_game_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/snoopy_game_sequencer.sv
// Game sequencer for the Snoopy runner: game state machine, frame tick pacing,
// buffered and rate-limited jump requests, physics reset control and run score.
module snoopy_game_sequencer #(
  parameter int TICK_DIV       = 833333,
  parameter int JUMP_BUF_TICKS = 4,
  parameter int MAX_JUMPS      = 2,
  parameter int GROUND_HEIGHT  = 100,
  parameter int DYING_TICKS    = 30,
  parameter int SCORE_WIDTH    = 14
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_btn,
  input  logic                   jump_btn,
  input  logic                   collision,
  input  logic [6:0]             snoopy_y,
  output logic                   frame_tick,
  output logic                   jump_req,
  output logic                   physics_rst_n,
  output logic [1:0]             game_state,
  output logic                   game_over,
  output logic [SCORE_WIDTH-1:0] score
);

  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    DYING   = 2'b10,
    OVER    = 2'b11
  } state_t;

  state_t state;
  state_t state_next;

  logic start_s1, start_s2, start_prev;
  logic jump_s1, jump_s2, jump_prev;
  logic start_edge, jump_edge;

  logic [TW-1:0] tick_cnt;
  logic [3:0]    buf_cnt;
  logic [1:0]    jumps_used;
  logic [7:0]    death_cnt;

  logic active;
  logic entering;
  logic grounded;
  logic death_done;

  // Registers reset high so a button held through reset never looks like a press.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_s1   <= 1'b1;
      start_s2   <= 1'b1;
      start_prev <= 1'b1;
      jump_s1    <= 1'b1;
      jump_s2    <= 1'b1;
      jump_prev  <= 1'b1;
    end else begin
      start_s1   <= start_btn;
      start_s2   <= start_s1;
      start_prev <= start_s2;
      jump_s1    <= jump_btn;
      jump_s2    <= jump_s1;
      jump_prev  <= jump_s2;
    end
  end

  assign start_edge = start_s2 & ~start_prev;
  assign jump_edge  = jump_s2 & ~jump_prev;

  assign active     = (state == RUNNING) || (state == DYING);
  assign grounded   = snoopy_y >= 7'(GROUND_HEIGHT);
  assign frame_tick = active && (tick_cnt == TW'(TICK_DIV - 1));
  assign death_done = frame_tick && (death_cnt == 8'(DYING_TICKS - 1));

  assign jump_req = frame_tick && (state == RUNNING) &&
                    ((buf_cnt != 4'd0) || jump_edge) &&
                    (jumps_used < 2'(MAX_JUMPS));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    physics_rst_n = 1'b1;
    game_over     = 1'b0;
    game_state    = state;
    case (state)
      IDLE: begin
        physics_rst_n = 1'b0;
        if (start_edge) state_next = RUNNING;
      end
      RUNNING: begin
        if (collision) state_next = DYING;
      end
      DYING: begin
        if (death_done) state_next = OVER;
      end
      OVER: begin
        game_over = 1'b1;
        if (start_edge) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign entering = (state_next != state);

  // Every state change restarts the frame period from zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (!active || entering || frame_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_cnt <= 4'd0;
    end else if (state != RUNNING) begin
      buf_cnt <= 4'd0;
    end else if (jump_req) begin
      buf_cnt <= 4'd0;
    end else if (jump_edge) begin
      buf_cnt <= 4'(JUMP_BUF_TICKS);
    end else if (frame_tick && (buf_cnt != 4'd0)) begin
      buf_cnt <= buf_cnt - 4'd1;
    end
  end

  // Landing clears the count, but a jump granted on the landing cycle still counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      jumps_used <= 2'd0;
    end else if ((state == IDLE) && start_edge) begin
      jumps_used <= 2'd0;
    end else if (grounded) begin
      jumps_used <= jump_req ? 2'd1 : 2'd0;
    end else if (jump_req) begin
      jumps_used <= jumps_used + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      death_cnt <= 8'd0;
    end else if ((state == RUNNING) && collision) begin
      death_cnt <= 8'd0;
    end else if ((state == DYING) && frame_tick) begin
      death_cnt <= death_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      score <= '0;
    end else if ((state == IDLE) && start_edge) begin
      score <= '0;
    end else if ((state == RUNNING) && frame_tick && (score != '1)) begin
      score <= score + SCORE_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_snoopy_game_sequencer.sv
// Bench for snoopy_game_sequencer: directed game scenarios followed by random
// play, all checked every cycle against a frame/event level model of the game.
module tb_snoopy_game_sequencer;

  localparam int TICK_DIV       = 4;
  localparam int JUMP_BUF_TICKS = 2;
  localparam int MAX_JUMPS      = 2;
  localparam int GROUND_HEIGHT  = 100;
  localparam int DYING_TICKS    = 3;
  localparam int SCORE_WIDTH    = 4;
  localparam int SCORE_MAX      = (1 << SCORE_WIDTH) - 1;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   start_btn;
  logic                   jump_btn;
  logic                   collision;
  logic [6:0]             snoopy_y;
  logic                   frame_tick;
  logic                   jump_req;
  logic                   physics_rst_n;
  logic [1:0]             game_state;
  logic                   game_over;
  logic [SCORE_WIDTH-1:0] score;

  int n_checks = 0;
  int n_fail   = 0;
  int jr_seen  = 0;

  // Model: state, cycles spent in the state, score, jumps this airborne period,
  // frames a jump press stays pending, dying frames seen, raw button samples.
  int       m_st, m_age, m_score, m_jumps, m_pend, m_deaths;
  bit [2:0] s_hist, j_hist;

  snoopy_game_sequencer #(
    .TICK_DIV(TICK_DIV),
    .JUMP_BUF_TICKS(JUMP_BUF_TICKS),
    .MAX_JUMPS(MAX_JUMPS),
    .GROUND_HEIGHT(GROUND_HEIGHT),
    .DYING_TICKS(DYING_TICKS),
    .SCORE_WIDTH(SCORE_WIDTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_btn(start_btn),
    .jump_btn(jump_btn),
    .collision(collision),
    .snoopy_y(snoopy_y),
    .frame_tick(frame_tick),
    .jump_req(jump_req),
    .physics_rst_n(physics_rst_n),
    .game_state(game_state),
    .game_over(game_over),
    .score(score)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_age = 0; m_score = 0; m_jumps = 0; m_pend = 0; m_deaths = 0;
    s_hist = 3'b111;
    j_hist = 3'b111;
  endtask

  // One clock cycle: predict, compare mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit ft, jr, se, je;
    int ns;
    se = s_hist[1] && !s_hist[2];
    je = j_hist[1] && !j_hist[2];
    ft = ((m_st == 1) || (m_st == 2)) && ((m_age % TICK_DIV) == TICK_DIV - 1);
    jr = ft && (m_st == 1) && ((m_pend > 0) || je) && (m_jumps < MAX_JUMPS);
    #4;
    check("frame_tick", frame_tick, ft);
    check("jump_req", jump_req, jr);
    check("physics_rst_n", physics_rst_n, m_st != 0);
    check("game_state", game_state, m_st);
    check("game_over", game_over, m_st == 3);
    check("score", score, m_score);
    if (jump_req) jr_seen++;
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      ns = m_st;
      if (m_st != 1) m_pend = 0;
      else if (jr) m_pend = 0;
      else if (je) m_pend = JUMP_BUF_TICKS;
      else if (ft && m_pend > 0) m_pend--;
      if (snoopy_y >= GROUND_HEIGHT) m_jumps = jr ? 1 : 0;
      else if (jr) m_jumps++;
      case (m_st)
        0: if (se) begin ns = 1; m_score = 0; m_jumps = 0; m_pend = 0; end
        1: begin
          if (ft && m_score < SCORE_MAX) m_score++;
          if (collision) begin ns = 2; m_deaths = 0; end
        end
        2: if (ft) begin
          if (m_deaths == DYING_TICKS - 1) ns = 3;
          else m_deaths++;
        end
        default: if (se) ns = 0;
      endcase
      m_age = (ns != m_st) ? 0 : m_age + 1;
      m_st = ns;
      s_hist = {s_hist[1:0], start_btn};
      j_hist = {j_hist[1:0], jump_btn};
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    cycle();
    start_btn = 1'b0;
    run(2);
  endtask

  task automatic press_jump();
    jump_btn = 1'b1;
    cycle();
    jump_btn = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_btn = 1'b0; jump_btn = 1'b0; collision = 1'b0;
    snoopy_y = 7'd100;
    model_reset();
    @(posedge clock);
    #1;
    run(2);
    reset = 1'b0;
    cycle();
    check("reset_state", game_state, 0);
    check("reset_physics", physics_rst_n, 0);

    // Start, then five frame ticks in twenty cycles.
    press_start();
    check("start_latency", game_state, 1);
    run(20);
    check("score_after_5", score, 5);

    // Airborne jumps: two granted, third blocked and its buffer expires.
    snoopy_y = 7'd90;
    jr_seen = 0; press_jump(); run(7);
    check("jump_first", jr_seen, 1);
    jr_seen = 0; press_jump(); run(7);
    check("jump_second", jr_seen, 1);
    jr_seen = 0; press_jump(); run(15);
    check("jump_blocked", jr_seen, 0);
    snoopy_y = 7'd100;
    jr_seen = 0; run(8);
    check("buf_expired", jr_seen, 0);
    jr_seen = 0; press_jump(); run(7);
    check("jump_regrounded", jr_seen, 1);
    check("score_saturated", score, 15);

    // Die, go over, back to idle with score held, then restart clears it.
    collision = 1'b1; cycle(); collision = 1'b0;
    run(12);
    check("over_reached", game_state, 3);
    press_start();
    check("over_to_idle", game_state, 0);
    check("idle_score_held", score, 15);
    press_start();
    check("restart_running", game_state, 1);
    check("restart_score", score, 0);

    // Collision on a tick still scores that tick; dying lasts twelve cycles.
    run(3);
    collision = 1'b1; cycle(); collision = 1'b0;
    check("collide_tick_score", score, 1);
    check("dying_entered", game_state, 2);
    run(11);
    check("dying_still", game_state, 2);
    run(1);
    check("dying_to_over", game_state, 3);
    check("over_flag", game_over, 1);
    check("over_score_frozen", score, 1);

    // Reset in the middle of dying with the jump button held throughout.
    press_start();
    press_start();
    run(8);
    collision = 1'b1; cycle(); collision = 1'b0;
    run(5);
    jump_btn = 1'b1;
    reset = 1'b1;
    cycle();
    check("midrst_state", game_state, 0);
    check("midrst_physics", physics_rst_n, 0);
    check("midrst_score", score, 0);
    reset = 1'b0;
    run(2);
    press_start();
    jr_seen = 0; run(16);
    check("held_jump_no_req", jr_seen, 0);
    jump_btn = 1'b0;

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 19) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 2) == 0) jump_btn = ~jump_btn;
      collision = ($urandom_range(0, 29) == 0);
      snoopy_y  = 7'($urandom_range(85, 110));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
